ula_arbiter_8_bits: RTL
=======================

# ula_arbiter_8_bits

Registered two-requester front end for the 8-bit ALU `ula_8_bits_structure`. Two independent clients issue ALU operations over valid/ready handshakes. The block arbitrates between them round-robin, captures operands, runs one operation through the shared ALU, and returns the tagged result on a single response channel with backpressure. It sits between the datapath sequencers and the combinational ALU, so every ALU output becomes a clean registered value.

## Interface
- No parameters; data width fixed at 8, opcode width fixed at 3.
- CLK  in  1  sole clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- REQ0_VALID  in  1  requester 0 has an operation pending.
- REQ0_READY  out  1  requester 0 operation accepted this cycle.
- REQ0_A, REQ0_B  in  8 each  requester 0 operands.
- REQ0_X  in  3  requester 0 opcode.
- REQ0_CIN  in  1  requester 0 carry/borrow in.
- REQ1_VALID, REQ1_READY, REQ1_A, REQ1_B, REQ1_X, REQ1_CIN  same as requester 0, for requester 1.
- RSP_VALID  out  1  response holds a result.
- RSP_READY  in  1  consumer takes the response.
- RSP_S  out  8  result.
- RSP_COUT  out  1  carry out (add) or borrow out (sub); 0 otherwise.
- RSP_ID  out  1  requester that issued the result.
- RSP_ERR  out  1  opcode was unsupported.

## Operation
- Opcodes:
  - 000 = A+B+CIN
  - 001 = A−B−CIN (borrow out on COUT)
  - 010 = A&B
  - 011 = A|B
  - 100 = ~A
  - 101/110/111 are illegal: RSP_S=0x00, RSP_COUT=0, RSP_ERR=1. The ALU output is ignored for illegal opcodes.
- FSM has three states: IDLE, EXEC, RESP.
  - IDLE: if any REQn_VALID, grant one requester and assert its REQn_READY combinationally in the same cycle. Capture A, B, X, CIN and the grant ID into operand registers, then go to EXEC. With no request, stay in IDLE.
  - EXEC: the ALU evaluates the captured operands. At the clock edge, register S, COUT, ERR and ID into the response registers, then go to RESP.
  - RESP: hold RSP_VALID=1. On RSP_VALID&&RSP_READY, go to IDLE.
- Arbitration:
  - Round-robin on a 1-bit LAST register holding the ID of the last granted requester.
  - With both requesters valid, grant ~LAST.
  - With one requester valid, grant it regardless of LAST.
  - LAST updates only on grant.
- REQn_READY is asserted only in IDLE and at most one at a time. Both are 0 in EXEC and RESP.
- Response outputs change only on the EXEC→RESP edge and are stable throughout RESP.

## Timing
- Accept in cycle N. EXEC in N+1. RSP_VALID=1 from N+2.
- Earliest next accept is the cycle after the RSP handshake. Peak throughput is one operation per 3 cycles.
- Backpressure: RSP_READY=0 holds RESP indefinitely. All RSP_* outputs stay stable and no request is accepted.
- A requester may drop VALID before it is granted; no grant is given to a deasserted VALID.
- Reset values, applied immediately on RST_N low in any state:
  - state=IDLE, LAST=1 (REQ0 wins the first tie)
  - RSP_VALID=0, RSP_S=0x00, RSP_COUT=0, RSP_ID=0, RSP_ERR=0
  - REQ0_READY=REQ1_READY=0
  - Operand registers cleared.
- Reset mid-EXEC or mid-RESP discards the in-flight operation; no response is produced for it.
- Arithmetic is modulo 256. COUT is the 9th bit of the add, or the final borrow of the sub.

## Structure
- Package `ula_pkg` holds:
  - opcode constants OP_ADD=3'b000, OP_SUB=3'b001, OP_AND=3'b010, OP_OR=3'b011, OP_NOT=3'b100
  - state enum {IDLE, EXEC, RESP}
  - function is_legal_op(X).
- One sub-module: the existing `ula_8_bits_structure`, instantiated once and driven from the operand registers. Its outputs are masked to 0 when the opcode is illegal.
- The arbiter logic and FSM stay in this module; no further sub-modules.

## Test plan
- Add with carry: REQ0 valid with A=0xFF, B=0x01, X=000, CIN=0. Expect REQ0_READY in cycle N; at N+2 RSP_S=0x00, COUT=1, ID=0, ERR=0.
- Sub with borrow: REQ1 with A=0x05, B=0x03, X=001, CIN=1. Expect RSP_S=0x01, COUT=0, ID=1. Repeat with A=0x03, B=0x05, CIN=0. Expect RSP_S=0xFE, COUT=1.
- Tie and fairness: after reset, both requesters held valid, RSP_READY=1 throughout. Grants alternate REQ0, REQ1, REQ0, REQ1 at accept cycles 3 apart; RSP_ID sequence is 0, 1, 0, 1.
- Backpressure: result A=0x0F & B=0x3C with RSP_READY=0 for 5 cycles. RSP_S=0x0C held stable, both READYs stay 0, and the result completes on the cycle RSP_READY rises.
- Illegal opcode and NOT:
  - X=111 gives RSP_S=0x00, COUT=0, ERR=1.
  - Then X=100 with A=0xA5 gives RSP_S=0x5A, ERR=0.
- Async reset in EXEC: pulse RST_N low between clock edges. All outputs go to reset values immediately, no RSP_VALID follows, and the next tie is granted to REQ0.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared opcode constants, FSM state type and opcode legality helper
// for the two-requester ALU front end and its combinational ALU.
package ula_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_NOT = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic is_legal_op(input logic [OP_W-1:0] x);
        return (x == OP_ADD) || (x == OP_SUB) || (x == OP_AND) ||
               (x == OP_OR)  || (x == OP_NOT);
    endfunction

endpackage

// File: rtl/ula_8_bits_structure.sv
// Combinational 8-bit ALU: add/sub with carry/borrow, and, or, not.
// Ports: A, B operands; X opcode; CIN carry/borrow in; S result; COUT carry/borrow out.
module ula_8_bits_structure
    import ula_pkg::*;
(
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [OP_W-1:0]   X,
    input  logic              CIN,
    output logic [DATA_W-1:0] S,
    output logic              COUT
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] dif;

    // Ninth bit of the subtraction wraps to 1 exactly when a borrow occurs.
    assign sum = {1'b0, A} + {1'b0, B} + {{DATA_W{1'b0}}, CIN};
    assign dif = {1'b0, A} - {1'b0, B} - {{DATA_W{1'b0}}, CIN};

    always_comb begin
        S    = '0;
        COUT = 1'b0;
        unique case (X)
            OP_ADD: begin
                S    = sum[DATA_W-1:0];
                COUT = sum[DATA_W];
            end
            OP_SUB: begin
                S    = dif[DATA_W-1:0];
                COUT = dif[DATA_W];
            end
            OP_AND:  S = A & B;
            OP_OR:   S = A | B;
            OP_NOT:  S = ~A;
            default: begin
                S    = '0;
                COUT = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ula_arbiter_8_bits.sv
// Round-robin two-requester front end for the shared 8-bit ALU.
// Ports: REQn_* valid/ready request channels, RSP_* registered response channel.
module ula_arbiter_8_bits
    import ula_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              REQ0_VALID,
    output logic              REQ0_READY,
    input  logic [DATA_W-1:0] REQ0_A,
    input  logic [DATA_W-1:0] REQ0_B,
    input  logic [OP_W-1:0]   REQ0_X,
    input  logic              REQ0_CIN,
    input  logic              REQ1_VALID,
    output logic              REQ1_READY,
    input  logic [DATA_W-1:0] REQ1_A,
    input  logic [DATA_W-1:0] REQ1_B,
    input  logic [OP_W-1:0]   REQ1_X,
    input  logic              REQ1_CIN,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [DATA_W-1:0] RSP_S,
    output logic              RSP_COUT,
    output logic              RSP_ID,
    output logic              RSP_ERR
);

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [OP_W-1:0]   x_q, x_d;
    logic              cin_q, cin_d;
    logic              id_q, id_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_s_q, rsp_s_d;
    logic              rsp_cout_q, rsp_cout_d;
    logic              rsp_id_q, rsp_id_d;
    logic              rsp_err_q, rsp_err_d;

    logic [DATA_W-1:0] alu_s;
    logic              alu_cout;
    logic              any_req;
    logic              grant_id;
    logic              legal;

    ula_8_bits_structure u_alu (
        .A    (a_q),
        .B    (b_q),
        .X    (x_q),
        .CIN  (cin_q),
        .S    (alu_s),
        .COUT (alu_cout)
    );

    assign any_req = REQ0_VALID | REQ1_VALID;
    // On a tie the requester not served last wins; otherwise the lone one.
    assign grant_id = (REQ0_VALID & REQ1_VALID) ? ~last_q : REQ1_VALID;
    assign legal    = is_legal_op(x_q);

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        a_d         = a_q;
        b_d         = b_q;
        x_d         = x_q;
        cin_d       = cin_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_s_d     = rsp_s_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_id_d    = rsp_id_q;
        rsp_err_d   = rsp_err_q;
        REQ0_READY  = 1'b0;
        REQ1_READY  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    REQ0_READY = ~grant_id;
                    REQ1_READY = grant_id;
                    last_d     = grant_id;
                    id_d       = grant_id;
                    a_d        = grant_id ? REQ1_A   : REQ0_A;
                    b_d        = grant_id ? REQ1_B   : REQ0_B;
                    x_d        = grant_id ? REQ1_X   : REQ0_X;
                    cin_d      = grant_id ? REQ1_CIN : REQ0_CIN;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                rsp_valid_d = 1'b1;
                rsp_s_d     = legal ? alu_s : '0;
                rsp_cout_d  = legal & alu_cout;
                rsp_err_d   = ~legal;
                rsp_id_d    = id_q;
                state_d     = RESP;
            end
            RESP: begin
                // Result fields stay put after the handshake; only VALID drops.
                if (RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            a_q         <= '0;
            b_q         <= '0;
            x_q         <= '0;
            cin_q       <= 1'b0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_s_q     <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            a_q         <= a_d;
            b_q         <= b_d;
            x_q         <= x_d;
            cin_q       <= cin_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_s_q     <= rsp_s_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign RSP_VALID = rsp_valid_q;
    assign RSP_S     = rsp_s_q;
    assign RSP_COUT  = rsp_cout_q;
    assign RSP_ID    = rsp_id_q;
    assign RSP_ERR   = rsp_err_q;

endmodule
